serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter: N, 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 SHALL have port: in_valid  input  1  operand pair on a, b, bin is valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept an operand pair.
REQ-006 SHALL have port: a  input  N  minuend.
REQ-007 SHALL have port: b  input  N  subtrahend.
REQ-008 SHALL have port: bin  input  1  borrow-in.
REQ-009 SHALL have port: out_valid  output  1  diff and bout are valid.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port: diff  output  N  result, (a - b - bin) mod 2^N.
REQ-012 SHALL have port: bout  output  1  borrow-out; 1 iff a < b + bin (unsigned).

Function
REQ-013 SHALL implement FSM with states IDLE, SHIFT, DONE.
REQ-014 SHALL drive in_ready = 1 only in IDLE; SHALL drive out_valid = 1 only in DONE.
REQ-015 SHALL, in IDLE with in_valid = 1, capture a, b, bin into internal shift registers and borrow flop, clear bit counter to 0, and go to SHIFT on that edge.
REQ-016 SHALL ignore a, b, bin, in_valid in SHIFT and DONE.
REQ-017 SHALL, each SHIFT cycle, perform one full-subtractor step on operand LSBs and the borrow flop: d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
REQ-018 SHALL shift d into diff register from the MSB end and shift operand registers right by one, so after N steps diff bit k equals step-k result (LSB-first processing).
REQ-019 SHALL stay in SHIFT for exactly N cycles (counter 0..N-1), then go to DONE; latency from input handshake edge to out_valid = 1 is N+1 rising edges.
REQ-020 SHALL hold diff and bout stable throughout DONE; bout equals final borrow flop.
REQ-021 SHALL, in DONE with out_ready = 1, complete output handshake and go to IDLE on that edge; in_ready asserts the following cycle (no same-cycle input acceptance; throughput one result per N+2 cycles minimum).
REQ-022 SHALL remain in DONE indefinitely while out_ready = 0 (backpressure), with no change to outputs.
REQ-023 SHALL treat out_ready in IDLE or SHIFT as don't-care.
REQ-024 SHALL keep counter width ceil(log2(N))+1 and never wrap within an operation.
REQ-025 SHALL have no combinational path from in_valid or out_ready to any output.

Reset
REQ-026 SHALL, when rst_n = 0 at a rising edge, go to IDLE, clear diff to 0, bout to 0, borrow flop, counter and operand registers to 0, regardless of current state.
REQ-027 SHALL, after reset, output in_ready = 1, out_valid = 0, diff = 0, bout = 0.
REQ-028 SHALL abandon any operation in progress on reset (mid-SHIFT or DONE) with no result presented.
REQ-029 SHALL accept a new operand on the first edge with rst_n = 1 and in_valid = 1.

Verification
REQ-030 N=8, a=0x5A, b=0x1F, bin=0, out_ready=1 -> out_valid rises 9 edges after accept; diff=0x3B, bout=0; in_ready back 1 cycle later.
REQ-031 N=8, a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1 (wrap-around); also a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
REQ-032 N=8, a=0xFF, b=0xFF, bin=0 -> diff=0x00, bout=0; hold out_ready=0 for 5 cycles -> out_valid, diff, bout stable; in_ready stays 0; release -> IDLE next edge.
REQ-033 Assert rst_n=0 at SHIFT count 3 -> next cycle in_ready=1, out_valid=0, diff=0, bout=0; next op a=0x10, b=0x03 -> diff=0x0D, bout=0.
REQ-034 in_valid held 1 with changing a/b during SHIFT -> result reflects only captured pair; exhaustive N=2 sweep of all a, b, bin (32 cases) matches (a-b-bin) mod 4 and borrow.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial N-bit subtractor (a - b - bin) with a
// valid/ready handshake on each side. Operands are consumed LSB-first, one
// full-subtractor step per SHIFT cycle, and the result is held in DONE
// until the consumer accepts it.
module serial_subtractor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout
);

  // One extra bit over ceil(log2(N)) so the count up to N-1 never wraps.
  localparam int unsigned CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   diff_q, diff_d;
  logic           br_q, br_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           step_d;
  logic           step_br;

  // Single full-subtractor step on the current operand LSBs and borrow.
  always_comb begin
    step_d  = a_q[0] ^ b_q[0] ^ br_q;
    step_br = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  end

  // Next-state and datapath update; everything holds unless the state acts.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    br_d    = br_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        // Result bits enter at the MSB so step k ends up at diff bit k.
        diff_d = {step_d, diff_q[N-1:1]};
        a_d    = {1'b0, a_q[N-1:1]};
        b_d    = {1'b0, b_q[N-1:1]};
        br_d   = step_br;
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs depend only on registered state, never on in_valid/out_ready.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    diff      = diff_q;
    bout      = br_q;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed, table-driven checks of serial_subtractor
// at N=8 plus an exhaustive sweep of an N=2 instance.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       in_valid, in_ready, out_valid, out_ready, bin, bout;
  logic [7:0] a, b, diff;

  logic       in_valid2, in_ready2, out_valid2, out_ready2, bin2, bout2;
  logic [1:0] a2, b2, diff2;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout)
  );

  serial_subtractor #(.N(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .bin(bin2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .diff(diff2), .bout(bout2)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] ed;
    logic       eb;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Full operation on the N=8 instance with out_ready held high.
  task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                        input logic [7:0] ed, input logic eb, input string tag);
    int  edges;
    logic busy_bad;
    check({tag, "_in_ready_idle"}, in_ready, 1);
    a = av; b = bv; bin = bi; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    edges = 1;
    busy_bad = 1'b0;
    while (!out_valid && edges < 40) begin
      if (in_ready) busy_bad = 1'b1;
      tick();
      edges++;
    end
    check({tag, "_in_ready_busy"}, busy_bad, 0);
    check({tag, "_latency"}, edges, 9);
    check({tag, "_diff"}, diff, ed);
    check({tag, "_bout"}, bout, eb);
    tick();
    check({tag, "_out_valid_after"}, out_valid, 0);
    check({tag, "_in_ready_after"}, in_ready, 1);
  endtask

  initial begin
    vecs[0] = '{8'h5A, 8'h1F, 1'b0, 8'h3B, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h10, 8'h03, 1'b0, 8'h0D, 1'b0};
    vecs[5] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0};
    vecs[6] = '{8'h01, 8'h02, 1'b1, 8'hFE, 1'b1};
    vecs[7] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
    vecs[8] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1};
    vecs[9] = '{8'h3C, 8'h3C, 1'b1, 8'hFF, 1'b1};

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    in_valid2 = 1'b0; out_ready2 = 1'b1; a2 = '0; b2 = '0; bin2 = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);

    for (int i = 0; i < 10; i++) begin
      do_op8(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].ed, vecs[i].eb,
             $sformatf("vec%0d", i));
    end

    // Backpressure: result must hold while out_ready is low.
    begin
      int  edges;
      logic unstable;
      a = 8'hFF; b = 8'hFF; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      edges = 1;
      while (!out_valid && edges < 40) begin
        tick();
        edges++;
      end
      check("bp_latency", edges, 9);
      unstable = 1'b0;
      for (int k = 0; k < 5; k++) begin
        tick();
        if (out_valid !== 1'b1 || diff !== 8'h00 || bout !== 1'b0 || in_ready !== 1'b0)
          unstable = 1'b1;
      end
      check("bp_stable", unstable, 0);
      check("bp_diff", diff, 8'h00);
      check("bp_in_ready", in_ready, 0);
      out_ready = 1'b1;
      tick();
      check("bp_release_out_valid", out_valid, 0);
      check("bp_release_in_ready", in_ready, 1);
    end

    // Reset at SHIFT count 3 abandons the operation.
    a = 8'h5A; b = 8'h1F; bin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_diff", diff, 0);
    check("midrst_bout", bout, 0);
    do_op8(8'h10, 8'h03, 1'b0, 8'h0D, 1'b0, "post_rst");

    // Inputs changing during SHIFT with in_valid held high are ignored.
    begin
      int edges;
      a = 8'h5A; b = 8'h1F; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      edges = 1;
      while (!out_valid && edges < 40) begin
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        tick();
        edges++;
      end
      in_valid = 1'b0;
      check("noisy_latency", edges, 9);
      check("noisy_diff", diff, 8'h3B);
      check("noisy_bout", bout, 0);
      tick();
      check("noisy_in_ready", in_ready, 1);
    end

    // Exhaustive N=2 sweep.
    for (int i = 0; i < 32; i++) begin
      logic [4:0] iv;
      int         full;
      int         edges;
      iv = i[4:0];
      full = int'(iv[4:3]) - int'(iv[2:1]) - int'(iv[0]);
      a2 = iv[4:3]; b2 = iv[2:1]; bin2 = iv[0]; in_valid2 = 1'b1;
      tick();
      in_valid2 = 1'b0;
      edges = 1;
      while (!out_valid2 && edges < 20) begin
        tick();
        edges++;
      end
      check($sformatf("n2_lat_%0d", i), edges, 3);
      check($sformatf("n2_diff_%0d", i), diff2, full & 3);
      check($sformatf("n2_bout_%0d", i), bout2, (full < 0) ? 1 : 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
